// File: rtl/cb_wb_arbiter.sv
// cb_wb_arbiter: writeback arbiter in front of the completion buffer.
// Four result sources (0=arith, 1=mul, 2=div, 3=load/store) each own one
// holding slot. A round-robin pick among held slots is presented to the
// completion buffer. A same-cycle drain and reload of a slot is allowed.
//
// Ports:
//   CLK, RST       clock, asynchronous active-high reset
//   src_valid/src_ready            per-source handshake
//   src_index/src_vd/src_wdata/src_exception   per-source result fields
//   flush          discard all held results, block accepts
//   cb_stall       completion buffer refuses this cycle
//   cb_valid/cb_index/cb_vd/cb_wdata/cb_exception/cb_src  presented result
//   perf_grants/perf_conflicts     saturating perf counters
//
// Optional feature: define CB_WB_ARBITER_PERF_EN to build the perf counters;
// otherwise both perf outputs are tied to zero.
module cb_wb_arbiter #(
  parameter int NUM_CB_ENTRY = 16,
  parameter int NUM_SRC      = 4,
  localparam int IW          = $clog2(NUM_CB_ENTRY)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [3:0]        src_valid,
  output logic [3:0]        src_ready,
  input  logic [4*IW-1:0]   src_index,
  input  logic [4*5-1:0]    src_vd,
  input  logic [4*32-1:0]   src_wdata,
  input  logic [3:0]        src_exception,
  input  logic              flush,
  input  logic              cb_stall,
  output logic              cb_valid,
  output logic [IW-1:0]     cb_index,
  output logic [4:0]        cb_vd,
  output logic [31:0]       cb_wdata,
  output logic              cb_exception,
  output logic [1:0]        cb_src,
  output logic [15:0]       perf_grants,
  output logic [15:0]       perf_conflicts
);

  localparam int unsigned NS = NUM_SRC;

  logic [3:0]    r_held;
  logic [IW-1:0] r_idx   [4];
  logic [4:0]    r_vd    [4];
  logic [31:0]   r_wdata [4];
  logic          r_exc   [4];
  logic [1:0]    r_rr;
  // A winner presented under stall is frozen so a newly accepted source
  // closer to the pointer cannot change the presented result mid-stall.
  logic          r_lock;
  logic [1:0]    r_lock_src;
  logic [IW-1:0] r_last_idx;
  logic [4:0]    r_last_vd;
  logic [31:0]   r_last_wdata;
  logic          r_last_exc;
  logic [1:0]    r_last_src;

  logic [1:0] w_search;
  logic [1:0] w_win;
  logic       w_any;
  logic       w_grant;

  always_comb begin
    logic       found;
    logic [1:0] j;
    found    = 1'b0;
    w_search = '0;
    j        = '0;
    for (int unsigned k = 0; k < NS; k++) begin
      j = r_rr + k[1:0];
      if (!found && r_held[j]) begin
        found    = 1'b1;
        w_search = j;
      end
    end
  end

  assign w_win    = r_lock ? r_lock_src : w_search;
  assign w_any    = |r_held;
  assign cb_valid = w_any && !flush;
  assign w_grant  = cb_valid && !cb_stall;

  always_comb begin
    src_ready = '0;
    for (int unsigned i = 0; i < NS; i++) begin
      src_ready[i] = !flush && (!r_held[i] || (w_grant && (w_win == i[1:0])));
    end
  end

  // With nothing held the last presented values are repeated.
  assign cb_index     = w_any ? r_idx[w_win]   : r_last_idx;
  assign cb_vd        = w_any ? r_vd[w_win]    : r_last_vd;
  assign cb_wdata     = w_any ? r_wdata[w_win] : r_last_wdata;
  assign cb_exception = w_any ? r_exc[w_win]   : r_last_exc;
  assign cb_src       = w_any ? w_win          : r_last_src;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_held       <= '0;
      r_rr         <= '0;
      r_lock       <= 1'b0;
      r_lock_src   <= '0;
      r_last_idx   <= '0;
      r_last_vd    <= '0;
      r_last_wdata <= '0;
      r_last_exc   <= 1'b0;
      r_last_src   <= '0;
      for (int unsigned i = 0; i < NS; i++) begin
        r_idx[i]   <= '0;
        r_vd[i]    <= '0;
        r_wdata[i] <= '0;
        r_exc[i]   <= 1'b0;
      end
    end else begin
      if (w_any) begin
        r_last_idx   <= cb_index;
        r_last_vd    <= cb_vd;
        r_last_wdata <= cb_wdata;
        r_last_exc   <= cb_exception;
        r_last_src   <= cb_src;
      end
      if (flush) begin
        r_held <= '0;
        r_lock <= 1'b0;
      end else begin
        for (int unsigned i = 0; i < NS; i++) begin
          if (w_grant && (w_win == i[1:0])) r_held[i] <= 1'b0;
          // Accept after clear so a drained slot can reload in the same cycle.
          if (src_valid[i] && src_ready[i]) begin
            r_held[i]  <= 1'b1;
            r_idx[i]   <= src_index[i*IW +: IW];
            r_vd[i]    <= src_vd[i*5 +: 5];
            r_wdata[i] <= src_wdata[i*32 +: 32];
            r_exc[i]   <= src_exception[i];
          end
        end
        if (w_grant) r_rr <= w_win + 2'd1;
        r_lock     <= cb_valid && cb_stall;
        r_lock_src <= w_win;
      end
    end
  end

`ifdef CB_WB_ARBITER_PERF_EN
  logic [15:0] r_perf_grants;
  logic [15:0] r_perf_conflicts;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_perf_grants    <= '0;
      r_perf_conflicts <= '0;
    end else begin
      if (w_grant && (r_perf_grants != '1)) r_perf_grants <= r_perf_grants + 16'd1;
      if (!flush && ($countones(r_held) >= 2) && (r_perf_conflicts != '1))
        r_perf_conflicts <= r_perf_conflicts + 16'd1;
    end
  end

  assign perf_grants    = r_perf_grants;
  assign perf_conflicts = r_perf_conflicts;
`else
  assign perf_grants    = '0;
  assign perf_conflicts = '0;
`endif

endmodule

// File: tb/tb_cb_wb_arbiter.sv
// Self-checking bench for cb_wb_arbiter: directed scenarios plus random
// traffic, checked through an expected-response queue against a slot model.
module tb_cb_wb_arbiter;
  localparam int IW = 4;

  logic            CLK = 1'b0;
  logic            RST;
  logic [3:0]      src_valid;
  logic [3:0]      src_ready;
  logic [4*IW-1:0] src_index;
  logic [19:0]     src_vd;
  logic [127:0]    src_wdata;
  logic [3:0]      src_exception;
  logic            flush;
  logic            cb_stall;
  logic            cb_valid;
  logic [IW-1:0]   cb_index;
  logic [4:0]      cb_vd;
  logic [31:0]     cb_wdata;
  logic            cb_exception;
  logic [1:0]      cb_src;
  logic [15:0]     perf_grants;
  logic [15:0]     perf_conflicts;

  cb_wb_arbiter #(.NUM_CB_ENTRY(16)) dut (
    .CLK(CLK), .RST(RST),
    .src_valid(src_valid), .src_ready(src_ready),
    .src_index(src_index), .src_vd(src_vd), .src_wdata(src_wdata),
    .src_exception(src_exception),
    .flush(flush), .cb_stall(cb_stall),
    .cb_valid(cb_valid), .cb_index(cb_index), .cb_vd(cb_vd),
    .cb_wdata(cb_wdata), .cb_exception(cb_exception), .cb_src(cb_src),
    .perf_grants(perf_grants), .perf_conflicts(perf_conflicts)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one slot per source, a rotating priority start point,
  // and a frozen pick while the completion buffer is stalling.
  typedef struct {
    bit          v;
    int          src;
    logic [3:0]  idx;
    logic [4:0]  vd;
    logic [31:0] wd;
    bit          ex;
    logic [3:0]  rdy;
  } exp_t;

  exp_t        q[$];
  exp_t        cur;
  bit          m_held[4];
  logic [3:0]  m_idx[4];
  logic [4:0]  m_vd[4];
  logic [31:0] m_wd[4];
  bit          m_ex[4];
  int          m_start;
  bit          m_frozen;
  int          m_frozen_src;
  int          m_grants;
  int          m_conf;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_held[i] = 0;
    m_start = 0; m_frozen = 0; m_frozen_src = 0;
    m_grants = 0; m_conf = 0;
  endtask

  task automatic set_src(input int i, input logic [3:0] idx, input logic [4:0] vd,
                         input logic [31:0] wd, input bit ex);
    src_index[i*IW +: IW] = idx;
    src_vd[i*5 +: 5]      = vd;
    src_wdata[i*32 +: 32] = wd;
    src_exception[i]      = ex;
  endtask

  task automatic rnd_data();
    for (int i = 0; i < 4; i++)
      set_src(i, 4'($urandom), 5'($urandom), $urandom, 1'($urandom));
  endtask

  // Apply inputs for this cycle and queue what the DUT should present.
  task automatic drive(input logic [3:0] v, input logic fl, input logic st);
    exp_t e;
    int   cnt;
    src_valid = v; flush = fl; cb_stall = st;
    cnt = 0;
    for (int i = 0; i < 4; i++) cnt += m_held[i];
    e.v = (cnt > 0) && !fl;
    e.src = 0;
    if (m_frozen) e.src = m_frozen_src;
    else begin
      for (int k = 3; k >= 0; k--)
        if (m_held[(m_start + k) % 4]) e.src = (m_start + k) % 4;
    end
    e.idx = m_idx[e.src]; e.vd = m_vd[e.src]; e.wd = m_wd[e.src]; e.ex = m_ex[e.src];
    for (int i = 0; i < 4; i++)
      e.rdy[i] = !fl && (!m_held[i] || (e.v && !st && e.src == i));
    cur = e;
    q.push_back(e);
  endtask

  task automatic tick();
    int  cnt;
    bit  g;
    @(posedge CLK);
    cnt = 0;
    for (int i = 0; i < 4; i++) cnt += m_held[i];
    if (cnt >= 2 && !flush) m_conf++;
    if (flush) begin
      for (int i = 0; i < 4; i++) m_held[i] = 0;
      m_frozen = 0;
    end else begin
      g = cur.v && !cb_stall;
      if (g) begin
        m_held[cur.src] = 0;
        m_start = (cur.src + 1) % 4;
        m_grants++;
      end
      m_frozen = cur.v && cb_stall;
      m_frozen_src = cur.src;
      for (int i = 0; i < 4; i++)
        if (src_valid[i] && cur.rdy[i]) begin
          m_held[i] = 1;
          m_idx[i] = src_index[i*IW +: IW];
          m_vd[i]  = src_vd[i*5 +: 5];
          m_wd[i]  = src_wdata[i*32 +: 32];
          m_ex[i]  = src_exception[i];
        end
    end
    #1;
  endtask

  task automatic do_reset();
    src_valid = '0; flush = 1'b0; cb_stall = 1'b0;
    RST = 1'b1;
    q.delete();
    model_reset();
    #1;
    chk("reset_cb_valid", 32'(cb_valid), 0);
    chk("reset_cb_src", 32'(cb_src), 0);
    chk("reset_cb_index", 32'(cb_index), 0);
    chk("reset_cb_wdata", cb_wdata, 0);
    chk("reset_src_ready", 32'(src_ready), 32'hF);
    @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  // Monitor: compares the DUT presentation against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (!RST && q.size() > 0) begin
        e = q.pop_front();
        chk("sb_cb_valid", 32'(cb_valid), 32'(e.v));
        chk("sb_src_ready", 32'(src_ready), 32'(e.rdy));
        if (e.v) begin
          chk("sb_cb_src", 32'(cb_src), 32'(e.src));
          chk("sb_cb_index", 32'(cb_index), 32'(e.idx));
          chk("sb_cb_vd", 32'(cb_vd), 32'(e.vd));
          chk("sb_cb_wdata", cb_wdata, e.wd);
          chk("sb_cb_exception", 32'(cb_exception), 32'(e.ex));
        end
      end
    end
  end

  initial begin
    src_index = '0; src_vd = '0; src_wdata = '0; src_exception = '0;
    for (int i = 0; i < 4; i++) begin
      m_idx[i] = '0; m_vd[i] = '0; m_wd[i] = '0; m_ex[i] = 0;
    end
    #2 do_reset();

    // Single source, one-cycle latency.
    rnd_data();
    set_src(0, 4'd3, 5'd7, 32'hDEADBEEF, 0);
    drive(4'b0001, 0, 0); tick();
    drive(4'b0000, 0, 0); #1;
    chk("single_valid", 32'(cb_valid), 1);
    chk("single_src", 32'(cb_src), 0);
    chk("single_index", 32'(cb_index), 3);
    chk("single_wdata", cb_wdata, 32'hDEADBEEF);
    tick();
    drive(4'b0000, 0, 0); #1;
    chk("single_after", 32'(cb_valid), 0);
    tick();

    // Round robin from a fresh pointer.
    do_reset();
    rnd_data();
    drive(4'b1111, 0, 0); tick();
    for (int g = 0; g < 4; g++) begin
      drive(4'b0000, 0, 0); #1;
      chk("rr_order", 32'(cb_src), 32'(g));
      tick();
    end
    drive(4'b0000, 0, 0); tick();
`ifdef CB_WB_ARBITER_PERF_EN
    chk("rr_conflicts", 32'(perf_conflicts), 3);
    chk("rr_grants", 32'(perf_grants), 4);
`endif

    // Stall holds the presented result.
    rnd_data();
    drive(4'b0100, 0, 0); tick();
    for (int s = 0; s < 3; s++) begin
      drive(4'b0000, 0, 1); #1;
      chk("stall_valid", 32'(cb_valid), 1);
      chk("stall_src", 32'(cb_src), 2);
      chk("stall_ready2", 32'(src_ready[2]), 0);
      tick();
    end
    drive(4'b0000, 0, 0); #1;
    chk("stall_release_ready2", 32'(src_ready[2]), 1);
    tick();

    // Drain and reload.
    rnd_data();
    drive(4'b0010, 0, 0); tick();
    rnd_data();
    set_src(1, 4'd9, 5'd1, 32'h5, 0);
    drive(4'b0010, 0, 0); tick();
    drive(4'b0000, 0, 0); #1;
    chk("reload_src", 32'(cb_src), 1);
    chk("reload_wdata", cb_wdata, 32'h5);
    tick();

    // Flush with two held sources.
    rnd_data();
    drive(4'b1001, 0, 1); tick();
    drive(4'b0000, 1, 0); #1;
    chk("flush_valid", 32'(cb_valid), 0);
    chk("flush_ready", 32'(src_ready), 0);
    tick();
    drive(4'b0000, 0, 0); #1;
    chk("flush_after", 32'(cb_valid), 0);
    tick();

    // Reset in the middle of operation.
    rnd_data();
    drive(4'b0110, 0, 0); tick();
    drive(4'b0000, 0, 0);
    #1 RST = 1'b1;
    q.delete();
    model_reset();
    #1 chk("rst_mid_valid", 32'(cb_valid), 0);
    @(posedge CLK);
    #1 RST = 1'b0;
    for (int c = 0; c < 2; c++) begin
      drive(4'b0000, 0, 0); #1;
      chk("rst_no_stale", 32'(cb_valid), 0);
      tick();
    end

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      rnd_data();
      drive(4'($urandom), ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0));
      tick();
    end
    for (int c = 0; c < 6; c++) begin
      drive(4'b0000, 0, 0); tick();
    end
    @(negedge CLK); #1;
    chk("queue_drained", 32'(q.size()), 0);
`ifdef CB_WB_ARBITER_PERF_EN
    chk("perf_grants", 32'(perf_grants), 32'(m_grants));
    chk("perf_conflicts", 32'(perf_conflicts), 32'(m_conf));
`else
    chk("perf_grants_tied", 32'(perf_grants), 0);
    chk("perf_conflicts_tied", 32'(perf_conflicts), 0);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
